// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vectors, FSM encoding and the
// default exception entry point.
package pipe_ctrl_pkg;

    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    // Each request freezes its own stage and everything upstream of it.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pipe_stall_wdog.sv
// Watchdog on the IF/ID hold bit: counts consecutive held cycles and raises a
// sticky flag once the run length reaches TIMEOUT.
module pipe_stall_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic hold,
    input  logic cnt_clr,
    output logic stall_timeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] run_len;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_len       <= 16'd0;
            stall_timeout <= 1'b0;
        end else if (cnt_clr) begin
            run_len       <= 16'd0;
            stall_timeout <= 1'b0;
        end else begin
            // Counter parks at its maximum so a very long stall never wraps.
            if (!hold)
                run_len <= 16'd0;
            else if (run_len != 16'hFFFF)
                run_len <= run_len + 16'd1;
            if (hold && (run_len == LIMIT - 16'd1))
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges per-stage stall requests, sequences
// exception/ERET redirects through DRAIN and FLUSH, and keeps statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic        excp_eret,
    input  logic [31:0] epc,
    input  logic        cnt_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        new_pc_valid,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        stall_timeout
);

    pc_state_t state;
    logic      stall_cnt_en;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall = STALL_NONE;
        case (state)
            ST_RUN: begin
                if (excp_valid)        stall = STALL_ALL;
                else if (stallreq_mem) stall = STALL_MEM;
                else if (stallreq_ex)  stall = STALL_EX;
                else if (stallreq_id)  stall = STALL_ID;
                else if (stallreq_if)  stall = STALL_IF;
            end
            ST_DRAIN: stall = STALL_ALL;
            default:  stall = STALL_NONE;
        endcase
    end

    // Redirect sequencer; flush/new_pc_valid are registered on entry to FLUSH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_RUN;
            flush        <= 1'b0;
            new_pc_valid <= 1'b0;
            new_pc       <= ZeroWord;
        end else begin
            case (state)
                ST_RUN: begin
                    if (excp_valid) begin
                        new_pc <= excp_eret ? epc : EXC_VECTOR;
                        if (stallreq_if) begin
                            state <= ST_DRAIN;
                        end else begin
                            state        <= ST_FLUSH;
                            flush        <= 1'b1;
                            new_pc_valid <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!stallreq_if) begin
                        state        <= ST_FLUSH;
                        flush        <= 1'b1;
                        new_pc_valid <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_RUN;
                    flush        <= 1'b0;
                    new_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign stall_cnt_en = (state == ST_RUN) && !excp_valid && (stall[0] == Stop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= ZeroWord;
            flush_count  <= 16'd0;
        end else if (cnt_clr) begin
            stall_cycles <= ZeroWord;
            flush_count  <= 16'd0;
        end else begin
            if (stall_cnt_en)
                stall_cycles <= sat_inc32(stall_cycles);
            if (state == ST_FLUSH)
                flush_count <= flush_count + 16'd1;
        end
    end

    pipe_stall_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk           (clk),
        .resetn        (resetn),
        .hold          (stall[1]),
        .cnt_clr       (cnt_clr),
        .stall_timeout (stall_timeout)
    );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, exception handler entry PC.
REQ-002 SHALL have parameter TIMEOUT, default 1024, consecutive-stall watchdog limit in cycles (range 2..65535).
REQ-003 SHALL have port clk input 1: clock.
REQ-004 SHALL have port resetn input 1: reset; asynchronous, active-low.
REQ-005 SHALL have ports stallreq_if, stallreq_id, stallreq_ex, stallreq_mem input 1 each: per-stage stall requests.
REQ-006 SHALL have port excp_valid input 1: exception or ERET committed in MEM.
REQ-007 SHALL have port excp_eret input 1: qualifies excp_valid as ERET.
REQ-008 SHALL have port epc input 32: ERET return address.
REQ-009 SHALL have port cnt_clr input 1: synchronous clear of statistics and timeout flag.
REQ-010 SHALL have port stall output 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 means hold.
REQ-011 SHALL have ports flush output 1 and new_pc_valid output 1: pipeline flush and redirect strobe.
REQ-012 SHALL have port new_pc output 32: redirect target.
REQ-013 SHALL have ports stall_cycles output 32, flush_count output 16, stall_timeout output 1: statistics.

Function
REQ-014 SHALL implement FSM states RUN, DRAIN, FLUSH.
REQ-015 In RUN with excp_valid=0, stall SHALL be driven combinationally by the highest-priority request: mem=6'b011111, ex=6'b001111, id=6'b000111, if=6'b000011, none=6'b000000.
REQ-016 In RUN with excp_valid=1, stall SHALL be 6'b111111 in that cycle, regardless of stall requests.
REQ-017 On that same clock edge, the target SHALL be captured into a register: epc if excp_eret=1, else EXC_VECTOR.
REQ-018 On that edge, next state SHALL be DRAIN if stallreq_if=1, else FLUSH.
REQ-019 In DRAIN, stall SHALL be 6'b111111 and flush SHALL be 0.
REQ-020 DRAIN SHALL transition to FLUSH on the first edge where stallreq_if=0.
REQ-021 FLUSH SHALL last exactly one cycle: flush=1, new_pc_valid=1, new_pc=captured target, stall=6'b000000; next state RUN.
REQ-022 excp_valid SHALL be ignored in DRAIN and FLUSH.
REQ-023 flush and new_pc_valid SHALL be 0 outside FLUSH.
REQ-024 new_pc SHALL hold its last captured value outside FLUSH.
REQ-025 stall_cycles SHALL increment by 1 per cycle in RUN with stall[0]=1 and excp_valid=0, saturating at 32'hFFFFFFFF.
REQ-026 flush_count SHALL increment by 1 per FLUSH cycle and wrap modulo 2^16.
REQ-027 A consecutive-stall counter SHALL count cycles with stall[1]=1 in any state and reset to 0 on any cycle with stall[1]=0.
REQ-028 stall_timeout SHALL set (sticky) on the edge where the consecutive-stall count reaches TIMEOUT.
REQ-029 cnt_clr=1 SHALL zero stall_cycles, flush_count, the consecutive-stall counter and stall_timeout, taking priority over any same-cycle increment or set.

Reset
REQ-030 While resetn=0, the following SHALL hold: state=RUN, flush=0, new_pc_valid=0, new_pc=0, stall_cycles=0, flush_count=0, stall_timeout=0, consecutive-stall counter=0.
REQ-031 Reset asserted in DRAIN or FLUSH SHALL abort the redirect without emitting flush.
REQ-032 After resetn deasserts, the block SHALL be in RUN with stall reflecting requests combinationally.

Structure
REQ-033 Stall-vector constants, FSM state encoding and EXC_VECTOR default SHALL live in the shared definitions package, alongside the existing Stop/NoStop and ZeroWord constants.
REQ-034 The consecutive-stall counter and timeout flag SHALL be one sub-module, pipe_stall_wdog; all other logic SHALL be in pipe_ctrl.

Verification
REQ-035 The bench SHALL cover: stallreq_id=1 and stallreq_mem=1 together in RUN -> stall=6'b011111 same cycle, stall_cycles +1 per cycle.
REQ-036 The bench SHALL cover: excp_valid=1, excp_eret=0, stallreq_if=0 -> stall=6'b111111 that cycle; next cycle flush=1, new_pc=32'hBFC00380, new_pc_valid=1; flush_count=1.
REQ-037 The bench SHALL cover: excp_valid=1, excp_eret=1, epc=32'h80001234, stallreq_if=1 for 3 more cycles -> 3 DRAIN cycles with stall=6'b111111, then one FLUSH cycle with new_pc=32'h80001234.
REQ-038 The bench SHALL cover: TIMEOUT=4, stallreq_ex held 4 cycles -> stall_timeout=1 after 4th edge and remains 1 after request drops; cnt_clr pulse -> 0.
REQ-039 The bench SHALL cover: resetn pulsed low during DRAIN -> flush never asserted, all outputs 0, state RUN.
REQ-040 The bench SHALL cover: stall_cycles preloaded near saturation via long stall -> holds at 32'hFFFFFFFF; cnt_clr concurrent with increment -> 0.
